// File: rtl/flash_bus_arbiter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | flash_bus_arbiter_pkg: shared types and widths for the flash arbiter    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package flash_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    FA_IDLE = 2'd0,
    FA_WAIT = 2'd1,
    FA_DONE = 2'd2
  } flash_arb_state_t;

  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 8;

endpackage
`default_nettype wire

// File: rtl/flash_bus_arbiter_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | flash_bus_arbiter_if: requester bundle plus the shared flash port       |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface flash_bus_arbiter_if
  import flash_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]              rq_ce;
  logic [N_REQ-1:0]              rq_we;
  logic [N_REQ*FLASH_ADDR_W-1:0] rq_base_addr;
  logic [N_REQ*FLASH_ADDR_W-1:0] rq_addr;
  logic [N_REQ*FLASH_DATA_W-1:0] rq_data;
  logic [FLASH_DATA_W-1:0]       rq_q;
  logic [N_REQ-1:0]              rq_valid;
  logic [FLASH_ADDR_W-1:0]       fl_base_addr;
  logic [FLASH_ADDR_W-1:0]       fl_addr;
  logic [FLASH_DATA_W-1:0]       fl_data_to_flash;
  logic                          fl_we;
  logic                          fl_ce;
  logic [FLASH_DATA_W-1:0]       fl_data_from_flash;
  logic                          fl_data_valid;
  logic [GW-1:0]                 grant;
  logic                          timeout_err;

  modport slave (
    input  rq_ce, rq_we, rq_base_addr, rq_addr, rq_data,
    input  fl_data_from_flash, fl_data_valid,
    output rq_q, rq_valid, fl_base_addr, fl_addr, fl_data_to_flash,
    output fl_we, fl_ce, grant, timeout_err
  );

  modport master (
    output rq_ce, rq_we, rq_base_addr, rq_addr, rq_data,
    output fl_data_from_flash, fl_data_valid,
    input  rq_q, rq_valid, fl_base_addr, fl_addr, fl_data_to_flash,
    input  fl_we, fl_ce, grant, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/flash_rr_pick.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | flash_rr_pick: combinational round-robin selector above last_grant      |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module flash_rr_pick #(
  parameter int N_REQ = 2,
  parameter int GW    = $clog2(N_REQ)
) (
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [GW-1:0]    last_grant,
  output logic                  hit,
  output logic [GW-1:0]         index
);

  // Scan from the farthest offset down so the nearest set bit above last_grant wins.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      logic [GW-1:0] w_cand;
      w_cand = GW'((int'(last_grant) + k) % N_REQ);
      if (req[w_cand]) begin
        hit   = 1'b1;
        index = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_bus_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | flash_bus_arbiter: round-robin sharing of one flash port, with timeout  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module flash_bus_arbiter
  import flash_bus_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1023
) (
  input  wire logic           clk,
  input  wire logic           reset,
  flash_bus_arbiter_if.slave  bus
);
  localparam int GW = $clog2(N_REQ);
  // A zero TIMEOUT still needs a 1-bit counter to keep the datapath legal.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] C_TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  flash_arb_state_t        r_state, w_state_n;
  logic [GW-1:0]           r_grant, w_grant_n;
  logic [GW-1:0]           r_last, w_last_n;
  logic [TW-1:0]           r_cnt, w_cnt_n;
  logic [FLASH_DATA_W-1:0] r_q, w_q_n;
  logic [N_REQ-1:0]        r_valid, w_valid_n;
  logic [FLASH_ADDR_W-1:0] r_base, w_base_n;
  logic [FLASH_ADDR_W-1:0] r_addr, w_addr_n;
  logic [FLASH_DATA_W-1:0] r_data, w_data_n;
  logic                    r_we, w_we_n;
  logic                    r_ce, w_ce_n;
  logic                    r_terr, w_terr_n;
  logic                    w_hit;
  logic [GW-1:0]           w_idx;
  logic                    w_to;

  flash_rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_pick (
    .req        (bus.rq_ce),
    .last_grant (r_last),
    .hit        (w_hit),
    .index      (w_idx)
  );

  assign w_to = (TIMEOUT != 0) && (r_cnt == C_TO_LAST);

  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_last_n  = r_last;
    w_cnt_n   = r_cnt;
    w_q_n     = r_q;
    w_valid_n = '0;
    w_base_n  = r_base;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    w_we_n    = r_we;
    w_ce_n    = r_ce;
    w_terr_n  = r_terr;
    case (r_state)
      FA_IDLE: begin
        w_ce_n = 1'b0;
        if (w_hit) begin
          w_grant_n = w_idx;
          w_last_n  = w_idx;
          w_base_n  = bus.rq_base_addr[w_idx*FLASH_ADDR_W +: FLASH_ADDR_W];
          w_addr_n  = bus.rq_addr[w_idx*FLASH_ADDR_W +: FLASH_ADDR_W];
          w_data_n  = bus.rq_data[w_idx*FLASH_DATA_W +: FLASH_DATA_W];
          w_we_n    = bus.rq_we[w_idx];
          w_ce_n    = 1'b1;
          w_cnt_n   = '0;
          w_state_n = FA_WAIT;
        end
      end
      FA_WAIT: begin
        w_cnt_n = r_cnt + TW'(1);
        // A flash ack in the timeout cycle wins: real data, no error.
        if (bus.fl_data_valid) begin
          if (!r_we) w_q_n = bus.fl_data_from_flash;
          w_valid_n[r_grant] = 1'b1;
          w_ce_n    = 1'b0;
          w_we_n    = 1'b0;
          w_state_n = FA_DONE;
        end else if (w_to) begin
          w_q_n     = 8'hFF;
          w_valid_n[r_grant] = 1'b1;
          w_ce_n    = 1'b0;
          w_we_n    = 1'b0;
          w_terr_n  = 1'b1;
          w_state_n = FA_DONE;
        end
      end
      FA_DONE: w_state_n = FA_IDLE;
      default: w_state_n = FA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FA_IDLE;
      r_grant <= '0;
      r_last  <= GW'(N_REQ - 1);
      r_cnt   <= '0;
      r_q     <= '0;
      r_valid <= '0;
      r_base  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_ce    <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_last  <= w_last_n;
      r_cnt   <= w_cnt_n;
      r_q     <= w_q_n;
      r_valid <= w_valid_n;
      r_base  <= w_base_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      r_we    <= w_we_n;
      r_ce    <= w_ce_n;
      r_terr  <= w_terr_n;
    end
  end

  assign bus.rq_q             = r_q;
  assign bus.rq_valid         = r_valid;
  assign bus.fl_base_addr     = r_base;
  assign bus.fl_addr          = r_addr;
  assign bus.fl_data_to_flash = r_data;
  assign bus.fl_we            = r_we;
  assign bus.fl_ce            = r_ce;
  assign bus.grant            = r_grant;
  assign bus.timeout_err      = r_terr;

endmodule
`default_nettype wire
